// File: rtl/phase_sequencer_if.sv
// Phase sequencer bus: instruction class inputs, memory/halt handshakes,
// phase vector, halt status and performance counter outputs.
interface phase_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       irfunc;
    logic             mem_ready;
    logic             halt_req;
    logic [4:0]       p;
    logic             instr_done;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output op, irfunc, mem_ready, halt_req,
        input  p, instr_done, halted, halt_cause,
        input  instr_count, cycle_count
    );

    modport slave (
        input  op, irfunc, mem_ready, halt_req,
        output p, instr_done, halted, halt_cause,
        output instr_count, cycle_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-cycle P0..P4 phase generator with memory stall, halt and watchdog.
// Optional counters enabled by defining PHASE_SEQ_PERF_COUNTERS_EN.
module phase_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              reset,
    phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_P0, S_P1, S_P2, S_P3, S_P4, S_HALT
    } state_t;

    localparam logic [15:0] TO     = 16'(TIMEOUT);
    localparam logic [1:0]  C_NONE = 2'b00;
    localparam logic [1:0]  C_REQ  = 2'b01;
    localparam logic [1:0]  C_SYS  = 2'b10;
    localparam logic [1:0]  C_WDOG = 2'b11;

    state_t      state;
    state_t      nxt;
    logic [4:0]  p_q;
    logic        halted_q;
    logic [1:0]  cause;
    logic [1:0]  nxt_cause;
    logic [15:0] stall_cnt;
    logic [15:0] stall_nxt;
    logic        br, st, ld, sys, mem_op;
    logic        stalled, wd_fire, done;

    function automatic logic [4:0] onehot(input state_t s);
        case (s)
            S_P0:    return 5'b00001;
            S_P1:    return 5'b00010;
            S_P2:    return 5'b00100;
            S_P3:    return 5'b01000;
            S_P4:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    always_comb begin
        br = 1'b0;
        st = 1'b0;
        ld = 1'b0;
        case (bus.op)
            6'b000100, 6'b000101, 6'b000110,
            6'b000111, 6'b000001:            br = 1'b1;
            6'b101011, 6'b101001, 6'b101000: st = 1'b1;
            6'b100011, 6'b100000, 6'b100100,
            6'b100001, 6'b100101:            ld = 1'b1;
            default: ;
        endcase
    end

    assign sys     = (bus.op == 6'b000000) && (bus.irfunc == 6'b001100);
    assign mem_op  = ld || st;
    assign stalled = !bus.mem_ready &&
                     (state == S_P0 || (state == S_P3 && mem_op));
    assign wd_fire = (TIMEOUT != 0) && stalled && (stall_cnt == TO);

    always_comb begin
        done = 1'b0;
        unique case (state)
            S_P1:    done = sys;
            S_P2:    done = br;
            S_P3:    done = st && bus.mem_ready;
            S_P4:    done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    always_comb begin
        nxt       = state;
        nxt_cause = cause;
        unique case (state)
            S_P0: begin
                if (bus.mem_ready) begin
                    nxt = S_P1;
                end else if (wd_fire) begin
                    nxt       = S_HALT;
                    nxt_cause = C_WDOG;
                end
            end
            S_P1: begin
                if (sys) begin
                    nxt       = S_HALT;
                    nxt_cause = C_SYS;
                end else begin
                    nxt = S_P2;
                end
            end
            S_P2: nxt = br ? S_P0 : S_P3;
            S_P3: begin
                if (!mem_op || (ld && bus.mem_ready)) begin
                    nxt = S_P4;
                end else if (bus.mem_ready) begin
                    nxt = S_P0;
                end else if (wd_fire) begin
                    nxt       = S_HALT;
                    nxt_cause = C_WDOG;
                end
            end
            S_P4: nxt = S_P0;
            S_HALT: begin
                if (cause == C_REQ && !bus.halt_req) begin
                    nxt       = S_P0;
                    nxt_cause = C_NONE;
                end
            end
            default: nxt = S_P0;
        endcase
        // syscall retires in P1 but its own halt outranks halt_req
        if (done && state != S_P1 && bus.halt_req) begin
            nxt       = S_HALT;
            nxt_cause = C_REQ;
        end
    end

    assign stall_nxt = (stalled && nxt == state) ? stall_cnt + 16'd1 : 16'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_P0;
            p_q       <= 5'b00001;
            halted_q  <= 1'b0;
            cause     <= C_NONE;
            stall_cnt <= 16'd0;
        end else begin
            state     <= nxt;
            p_q       <= onehot(nxt);
            halted_q  <= (nxt == S_HALT);
            cause     <= nxt_cause;
            stall_cnt <= stall_nxt;
        end
    end

    assign bus.p          = p_q;
    assign bus.instr_done = done;
    assign bus.halted     = halted_q;
    assign bus.halt_cause = cause;

`ifdef PHASE_SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] ccnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icnt <= '0;
            ccnt <= '0;
        end else begin
            if (done) icnt <= icnt + CNT_W'(1);
            if (state != S_HALT) ccnt <= ccnt + CNT_W'(1);
        end
    end

    assign bus.instr_count = icnt;
    assign bus.cycle_count = ccnt;
`else
    assign bus.instr_count = {CNT_W{1'b0}};
    assign bus.cycle_count = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multi-cycle phase generator for the MIPS core. Drives the one-hot phase vector `p[4:0]` consumed by the control unit:
- P0 fetch
- P1 decode / PC increment
- P2 execute / branch resolve
- P3 memory
- P4 writeback

Phase sequence depends on the instruction class decoded from the IR. The block stalls on memory wait and handles halt sources. It also runs a stall watchdog and optional performance counters.

Parameters:
- TIMEOUT, 255, maximum consecutive mem_ready-low cycles in a memory phase before a watchdog halt; 0 disables the watchdog; legal range 0..65535.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26]; valid from P1 until next P0.
- irfunc  in  6  IR[5:0]; valid from P1 until next P0.
- mem_ready  in  1  memory completion; low = wait.
- halt_req  in  1  external halt request (level).
- p  out  5  one-hot phase: bit n = Pn; 5'b00000 while halted.
- instr_done  out  1  high in the final cycle of each instruction.
- halted  out  1  high in HALT state.
- halt_cause  out  2  00 none, 01 halt_req, 10 syscall, 11 watchdog.
- instr_count  out  CNT_W  retired instructions (optional feature).
- cycle_count  out  CNT_W  non-halted cycles (optional feature).

Behaviour:
- States: S_P0, S_P1, S_P2, S_P3, S_P4, S_HALT. `p` is a registered one-hot of the state.
- Reset (reset=0, async):
  - state=S_P0, p=5'b00001
  - halt_cause=00, halted=0
  - stall counter=0, counters=0
- Instruction classes (from op/irfunc):
  - branch: op ∈ {000100, 000101, 000110, 000111, 000001}
  - store: op ∈ {101011, 101001, 101000}
  - load: op ∈ {100011, 100000, 100100, 100001, 100101}
  - syscall: op=000000 and irfunc=001100
  - all other encodings, including unknown: full class
- Transitions:
  - S_P0: stays while mem_ready=0; goes to S_P1 when mem_ready=1.
  - S_P1: goes to S_HALT (cause 10) if syscall, else S_P2.
  - S_P2: branch is final, goes to next-start; otherwise S_P3.
  - S_P3:
    - load/store: stays while mem_ready=0.
    - store: final when mem_ready=1, goes to next-start.
    - load: goes to S_P4 when mem_ready=1.
    - other classes: S_P4 unconditionally, ignoring mem_ready.
  - S_P4: final, goes to next-start.
- next-start: S_HALT (cause 01) if halt_req=1 in the final cycle, else S_P0.
- Latency per instruction, no stalls: branch 3, store 4, others 5 cycles.
- instr_done: combinational.
  - High in S_P2 for branch, S_P3 for store with mem_ready=1, and S_P4.
  - High in S_P1 for syscall (counts as retired).
  - Never high while stalled.
- Watchdog (TIMEOUT≠0):
  - 16-bit stall counter increments each cycle the block is stalled in S_P0, or in S_P3 for load/store, with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - When the counter equals TIMEOUT and mem_ready=0: next state is S_HALT, cause 11. mem_ready rising in that same cycle takes priority (normal advance).
- S_HALT:
  - p=0, halted=1.
  - Cause 01: returns to S_P0 on the first cycle halt_req=0; halt_cause clears to 00 on that edge.
  - Causes 10 and 11: sticky, exited only by reset.
- Priority when several halt sources apply in one cycle: syscall > watchdog > halt_req.
- Reset mid-instruction aborts immediately; no partial retirement counted.

Optional Feature:
- Macro: PHASE_SEQ_PERF_COUNTERS_EN.
- Defined:
  - instr_count increments on each cycle with instr_done=1.
  - cycle_count increments every cycle state≠S_HALT.
  - Both wrap modulo 2^CNT_W; both clear only on reset.
- Undefined: instr_count and cycle_count are tied to 0 and no counter flops are generated.

Test Plan:
- Reset release, mem_ready=1, op=000000/irfunc=100000 (add): p sequence 00001, 00010, 00100, 01000, 10000, 00001. instr_done high only in cycle 5; instr_count=1 after it (feature on).
- beq (op=000100) then sw (op=101011), mem_ready=1: p visits P0–P2 then P0–P3. instr_done in cycles 3 and 7; cycle_count=7.
- lw with mem_ready=0 for 3 cycles in P3: p holds 01000 for 4 cycles, then P4. instr_done only in P4.
- TIMEOUT=4, mem_ready stuck 0 in P0: after 5 stalled cycles p=0, halted=1, halt_cause=11. Holds indefinitely despite mem_ready=1; cleared only by reset.
- halt_req=1 during P4 of an add: next cycle p=0, halt_cause=01. halt_req→0 gives p=00001 one cycle later and halt_cause=00.
- syscall (op=000000/irfunc=001100): halt after P1, halt_cause=10, instr_count incremented. halt_req toggling has no effect. Async reset assertion mid-P3 forces p=00001 immediately.
